// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised register file: one write port, NUM_RD registered read ports,
//   elaboration-time read-during-write mode, a stall that freezes every read
//   port, an optional hard-wired zero register and a clear engine that walks
//   every entry to INIT_VALUE after reset or on request. The memory array has
//   no reset so it remains block-RAM inferable; the clear engine defines it.
//
// Ports
//   clk      in   1                     rising-edge clock
//   rst      in   1                     asynchronous reset, active low
//   rd_addr  in   NUM_RD*ADDR_WIDTH     port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data  out  NUM_RD*DATA_WIDTH     registered read data, same packing
//   wr_addr  in   ADDR_WIDTH            write address
//   wr_data  in   DATA_WIDTH            write data
//   wen      in   1                     write enable (honoured only in RUN)
//   stall    in   1                     holds every rd_data port
//   clr      in   1                     one-cycle request to re-clear (RUN only)
//   busy     out  1                     clear engine active
//
// Flow control: there is no valid/ready pair. busy=1 means writes are being
// discarded and reads return the clear value; stall=1 means rd_data is frozen
// while writes and the clear walk keep going underneath.
module regfile_mp #(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    NUM_RD      = 2,
  parameter int                    WRITE_FIRST = 1,
  parameter int                    ZERO_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wen,
  input  logic                         stall,
  input  logic                         clr,
  output logic                         busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // state_q is the FSM state, kept as a named signal for checkers to bind to.
  state_t                    state_q;
  logic [ADDR_WIDTH:0]       clr_cnt_q;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic                      wr_accept;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_next;

  // A user write is accepted only in RUN and never lands on the zero register.
  always_comb begin
    wr_accept = (state_q == ST_RUN) && wen &&
                !((ZERO_REG != 0) && (wr_addr == '0));
    mem_we    = (state_q == ST_CLEAR) || wr_accept;
    mem_waddr = (state_q == ST_CLEAR) ? clr_cnt_q[ADDR_WIDTH-1:0] : wr_addr;
    mem_wdata = (state_q == ST_CLEAR) ? INIT_VALUE : wr_data;
  end

  // Single write port, no reset: keeps the array RAM-inferable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Next read value per port. During CLEAR the array is only partly written,
  // so reads return the clear value rather than stale contents.
  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    ra      = '0;
    rd_next = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_next[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (state_q == ST_CLEAR) begin
        rd_next[i*DATA_WIDTH +: DATA_WIDTH] = INIT_VALUE;
      end else if ((WRITE_FIRST != 0) && wr_accept && (ra == wr_addr)) begin
        rd_next[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
      end else begin
        rd_next[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy      <= 1'b1;
      rd_data   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // clr is ignored here: the walk never restarts mid-way.
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
            busy    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (clr) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          busy    <= 1'b1;
        end
      endcase
      if (!stall) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW = 4;
  localparam int AW = 5;
  localparam int NR = 2;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR*DW-1:0]  rd_data_z;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wen;
  logic              stall;
  logic              clr;
  logic              busy;
  logic              busy_z;

  int n_checks;
  int n_fail;

  // Default build: write-first, no zero register.
  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen), .stall(stall),
    .clr(clr), .busy(busy)
  );

  // Second build on the same stimulus: read-first with a zero register.
  regfile_mp #(.WRITE_FIRST(0), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen), .stall(stall),
    .clr(clr), .busy(busy_z)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] r0();
    return 32'(rd_data[0 +: DW]);
  endfunction
  function automatic logic [31:0] r1();
    return 32'(rd_data[DW +: DW]);
  endfunction
  function automatic logic [31:0] z0();
    return 32'(rd_data_z[0 +: DW]);
  endfunction
  function automatic logic [31:0] z1();
    return 32'(rd_data_z[DW +: DW]);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic write(input int a, input int d);
    wen     = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    tick();
    wen     = 1'b0;
  endtask

  // busy must stay high for exactly 32 edges, then drop.
  task automatic clear_walk(input string tag);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check({tag, "_busy"}, 32'(busy), (k < 32) ? 32'd1 : 32'd0);
      check({tag, "_busy_z"}, 32'(busy_z), (k < 32) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic read_all(input string tag, input int exp);
    for (int i = 0; i < 32; i++) begin
      set_rd(i, 31 - i);
      tick();
      check({tag, "_p0"}, r0(), 32'(exp));
      check({tag, "_p1"}, r1(), 32'(exp));
      check({tag, "_z0"}, z0(), 32'(exp));
    end
  endtask

  // ---------------- stimulus / scoreboard ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wen      = 1'b0;
    stall    = 1'b0;
    clr      = 1'b0;

    // Reset held 3 cycles.
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd0", r0(), 32'd0);
    check("rst_rd1", r1(), 32'd0);
    rst = 1'b1;
    clear_walk("post_rst");
    read_all("init", 0);

    // Write 7 <- A, then read 7 on port0 and 3 on port1.
    write(7, 'hA);
    set_rd(7, 3);
    tick();
    check("wr_p0", r0(), 32'hA);
    check("wr_p1", r1(), 32'h0);
    check("wr_z0", z0(), 32'hA);

    // Read-during-write on entry 5.
    write(5, 'h3);
    set_rd(5, 5);
    wen = 1'b1; wr_addr = 5; wr_data = 4'hC;
    tick();
    wen = 1'b0;
    check("rdw_wf_p0", r0(), 32'hC);
    check("rdw_wf_p1", r1(), 32'hC);
    check("rdw_rf_p0", z0(), 32'h3);
    check("rdw_rf_p1", z1(), 32'h3);
    tick();
    check("rdw_rf_next_p0", z0(), 32'hC);
    check("rdw_rf_next_p1", z1(), 32'hC);
    check("rdw_wf_next_p0", r0(), 32'hC);

    // Stall: hold 0x6 from entry 9 while 9 is rewritten and addresses move.
    write(9, 'h6);
    set_rd(9, 3);
    tick();
    check("pre_stall_p0", r0(), 32'h6);
    check("pre_stall_z0", z0(), 32'h6);
    stall = 1'b1;
    wen = 1'b1; wr_addr = 9; wr_data = 4'hF;
    for (int i = 0; i < 4; i++) begin
      set_rd(10 + i, 7);
      tick();
      check("stall_p0", r0(), 32'h6);
      check("stall_p1", r1(), 32'h0);
      check("stall_z0", z0(), 32'h6);
    end
    stall = 1'b0;
    wen   = 1'b0;
    set_rd(9, 7);
    tick();
    check("unstall_p0", r0(), 32'hF);
    check("unstall_p1", r1(), 32'hA);
    check("unstall_z0", z0(), 32'hF);

    // Zero register: dut_z drops writes to 0 and reads it as 0.
    write(0, 'h5);
    set_rd(0, 0);
    tick();
    check("zero_plain_p0", r0(), 32'h5);
    check("zero_z0", z0(), 32'h0);
    check("zero_z1", z1(), 32'h0);
    wen = 1'b1; wr_addr = 0; wr_data = 4'h7;
    tick();
    wen = 1'b0;
    check("zero_byp_plain", r0(), 32'h7);
    check("zero_byp_z0", z0(), 32'h0);

    // clr with a same-edge write, plus clr and wen during the walk.
    for (int i = 0; i < 32; i++) write(i, 'h1);
    set_rd(31, 2);
    tick();
    check("fill_p0", r0(), 32'h1);
    check("fill_p1", r1(), 32'h1);
    clr = 1'b1;
    wen = 1'b1; wr_addr = 2; wr_data = 4'h9;
    tick();
    clr = 1'b0;
    wen = 1'b0;
    check("clr_req_busy", 32'(busy), 32'd1);
    check("clr_req_byp", r1(), 32'h9);
    for (int k = 1; k <= 32; k++) begin
      clr = (k == 5);
      wen = (k == 20);
      wr_addr = 3; wr_data = 4'hE;
      tick();
      check("clr_busy", 32'(busy), (k < 32) ? 32'd1 : 32'd0);
      if (k == 1) check("clr_rd_init", r0(), 32'h0);
    end
    clr = 1'b0;
    wen = 1'b0;
    read_all("after_clr", 0);

    // Reset asserted while running: outputs clear without a clock edge.
    for (int i = 0; i < 4; i++) write(i, 'h1);
    set_rd(2, 3);
    tick();
    check("run_pre_rst", r0(), 32'h1);
    rst = 1'b0;
    #1;
    check("run_rst_busy", 32'(busy), 32'd1);
    check("run_rst_p0", r0(), 32'h0);
    check("run_rst_p1", r1(), 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    clear_walk("run_rst");

    // Reset at step 10 of a clr walk: full 32-edge walk after release.
    for (int i = 0; i < 4; i++) write(i, 'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    check("midclr_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midclr_rst_busy", 32'(busy), 32'd1);
    check("midclr_rst_p0", r0(), 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    clear_walk("midclr_rst");
    read_all("after_midclr", 0);

    // First write right after the walk is accepted.
    write(4, 'hB);
    set_rd(4, 4);
    tick();
    check("post_walk_wr", r0(), 32'hB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
